irq_controller: RTL and testbench

Interrupt controller for the 5-stage MIPS core, sitting at the responder end of the core's `interrupter` / `interrupter_no` inputs and its data-memory bus. It synchronizes eight external request lines, edge-detects them into a pending register, and masks them with an enable register. It then delivers the highest-priority request to the core and holds it until the handler writes end-of-interrupt (EOI) through a small memory-mapped register window.

---
 rtl/irq_controller_pkg.sv | 38 +++
 rtl/irq_controller_sync_edge.sv | 37 +++
 rtl/irq_controller.sv | 134 +++++++++++++
 tb/tb_irq_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants, bus request payload and priority helper for the interrupt controller.
package irq_controller_pkg;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned SRC_W   = 3;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_LSB = 2;
  localparam int unsigned WIN_LSB = 5;

  // Register selects (bus_addr[4:2]) within the window.
  localparam logic [SEL_W-1:0] IRQ_PENDING = 3'd0;
  localparam logic [SEL_W-1:0] IRQ_ENABLE  = 3'd1;
  localparam logic [SEL_W-1:0] IRQ_CURRENT = 3'd2;
  localparam logic [SEL_W-1:0] IRQ_EOI     = 3'd3;
  localparam logic [SEL_W-1:0] IRQ_SOFT    = 3'd4;

  localparam logic [0:0] IRQ_IDLE   = 1'b0;
  localparam logic [0:0] IRQ_ACTIVE = 1'b1;

  typedef struct packed {
    logic               ren;
    logic               wen;
    logic [SEL_W-1:0]   sel;
    logic [NUM_SRC-1:0] wdata;
  } irq_bus_req_t;

  // Lowest set index wins: source 0 is the highest priority.
  function automatic logic [SRC_W-1:0] irq_prio(input logic [NUM_SRC-1:0] cand);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_controller_sync_edge.sv
// Per-line synchronizer chain plus rising-edge detector for the eight request lines.
module irq_sync_edge
  import irq_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic [NUM_SRC-1:0] rise
);

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0]                  prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_in;
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/enable registers, MMIO window, priority select and
// a two-state delivery FSM that holds a source until the handler writes EOI.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               interrupter,
  output logic [SRC_W-1:0]   interrupter_no,
  input  logic               bus_ren,
  input  logic               bus_wen,
  input  logic [DATA_W-1:0]  bus_addr,
  input  logic [DATA_W-1:0]  bus_wdata,
  output logic [DATA_W-1:0]  bus_rdata,
  output logic               bus_hit
);

  logic [NUM_SRC-1:0] rise;
  irq_bus_req_t       req_c;
  logic               win_hit_c;
  logic               eoi_c;
  logic [NUM_SRC-1:0] cand_c;
  logic [DATA_W-1:0]  rd_val_c;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [0:0]         state_q, state_d;
  logic [SRC_W-1:0]   cur_no_q, cur_no_d;
  logic               irq_q, irq_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               hit_q, hit_d;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[SEL_LSB-1:0], bus_wdata[DATA_W-1:NUM_SRC]};

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .rise   (rise)
  );

  // Window decode into a compact request.
  always_comb begin
    win_hit_c   = (bus_addr[DATA_W-1:WIN_LSB] == BASE_ADDR[DATA_W-1:WIN_LSB]);
    req_c.ren   = bus_ren & win_hit_c;
    req_c.wen   = bus_wen & win_hit_c;
    req_c.sel   = bus_addr[SEL_LSB+SEL_W-1:SEL_LSB];
    req_c.wdata = bus_wdata[NUM_SRC-1:0];
  end

  // Read mux always sees pre-write register values.
  always_comb begin
    rd_val_c = '0;
    case (req_c.sel)
      IRQ_PENDING: rd_val_c = DATA_W'(pending_q);
      IRQ_ENABLE:  rd_val_c = DATA_W'(enable_q);
      IRQ_CURRENT: rd_val_c = {23'b0, (state_q == IRQ_ACTIVE), 5'b0, cur_no_q};
      default:     rd_val_c = '0;
    endcase
    rdata_d = req_c.ren ? rd_val_c : '0;
    hit_d   = req_c.ren;
  end

  // Register updates; an edge detect is applied last so set beats any clear.
  always_comb begin
    pending_d = pending_q;
    enable_d  = enable_q;
    eoi_c     = req_c.wen && (req_c.sel == IRQ_EOI) && (state_q == IRQ_ACTIVE);
    if (req_c.wen) begin
      case (req_c.sel)
        IRQ_PENDING: pending_d = pending_d & ~req_c.wdata;
        IRQ_ENABLE:  enable_d  = req_c.wdata;
        IRQ_SOFT:    pending_d = pending_d | req_c.wdata;
        default:     ;
      endcase
    end
    if (eoi_c) pending_d[cur_no_q] = 1'b0;
    pending_d = pending_d | rise;
  end

  // Delivery FSM: only EOI ends an active delivery.
  always_comb begin
    state_d  = state_q;
    cur_no_d = cur_no_q;
    irq_d    = 1'b0;
    cand_c   = pending_q & enable_q;
    case (state_q)
      IRQ_IDLE: begin
        if (|cand_c) begin
          state_d  = IRQ_ACTIVE;
          cur_no_d = irq_prio(cand_c);
        end
      end
      IRQ_ACTIVE: begin
        if (eoi_c) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
    irq_d = (state_d == IRQ_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
      state_q   <= IRQ_IDLE;
      cur_no_q  <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      state_q   <= state_d;
      cur_no_q  <= cur_no_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
    end
  end

  assign interrupter    = irq_q;
  assign interrupter_no = cur_no_q;
  assign bus_rdata      = rdata_q;
  assign bus_hit        = hit_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized + directed bench for irq_controller with a cycle-level reference model
// and a read-data scoreboard.
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int          SYNC = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_in;
  logic        interrupter;
  logic [2:0]  interrupter_no;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_hit;

  irq_controller #(
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_in         (irq_in),
    .interrupter    (interrupter),
    .interrupter_no (interrupter_no),
    .bus_ren        (bus_ren),
    .bus_wen        (bus_wen),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_hit        (bus_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: what software would observe, advanced once per clock edge.
  logic [7:0]  m_pend, m_en;
  bit          m_act;
  int          m_cur;
  logic [7:0]  hist [0:SYNC+1];   // hist[j] = irq_in sampled j edges ago
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model_read(input int sel);
    case (sel)
      0:       return 32'(m_pend);
      1:       return 32'(m_en);
      2:       return (32'(m_act) << 8) | 32'(m_cur);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] p, e, cand, rise_m;
    bit whit, eoi;
    int sel;
    for (int j = SYNC + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = irq_in;
    if (rst) begin
      for (int j = 0; j <= SYNC + 1; j++) hist[j] = 8'h00;
      m_pend = 8'h00;
      m_en   = 8'h00;
      m_act  = 0;
      m_cur  = 0;
    end else begin
      whit   = (bus_addr[31:5] == BASE[31:5]);
      sel    = int'(bus_addr[4:2]);
      if (bus_ren && whit) exp_q.push_back(model_read(sel));
      rise_m = hist[SYNC] & ~hist[SYNC+1];
      eoi    = bus_wen && whit && (sel == 3) && m_act;
      p = m_pend;
      e = m_en;
      if (bus_wen && whit) begin
        if (sel == 0) p = p & ~bus_wdata[7:0];
        if (sel == 1) e = bus_wdata[7:0];
        if (sel == 4) p = p | bus_wdata[7:0];
      end
      if (eoi) p[m_cur] = 1'b0;
      p = p | rise_m;
      cand = m_pend & m_en;
      if (!m_act && cand != 8'h00) begin
        m_act = 1;
        m_cur = $clog2(cand & (~cand + 8'd1));
      end else if (eoi) begin
        m_act = 0;
      end
      m_pend = p;
      m_en   = e;
    end
  end

  // Monitor: compares delivery outputs every cycle and pops read data when presented.
  always @(negedge clk) begin
    if (started) begin
      logic [31:0] exp_d;
      bit exp_hit;
      check("interrupter", 32'(interrupter), 32'(m_act));
      check("interrupter_no", 32'(interrupter_no), 32'(m_cur));
      exp_hit = (exp_q.size() != 0);
      check("bus_hit", 32'(bus_hit), 32'(exp_hit));
      if (exp_hit) begin
        exp_d = exp_q.pop_front();
        if (bus_hit) check("bus_rdata", bus_rdata, exp_d);
      end else begin
        check("bus_rdata_idle", bus_rdata, 32'h0);
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    bus_wen = 1'b1; bus_addr = addr; bus_wdata = d;
    @(negedge clk);
    bus_wen = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] addr);
    bus_ren = 1'b1; bus_addr = addr;
    @(negedge clk);
    bus_ren = 1'b0; bus_addr = 32'h0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'h00;
    bus_ren = 1'b0; bus_wen = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
    @(negedge clk);
    started = 1;
    @(negedge clk);
    check("reset_irq", 32'(interrupter), 32'h0);
    check("reset_no", 32'(interrupter_no), 32'h0);
    rst = 1'b0;

    // Single external source through the synchronizer.
    wr(BASE + 32'h04, 32'h08);
    irq_in = 8'h08;
    repeat (3) @(negedge clk);
    check("t1_not_yet", 32'(interrupter), 32'h0);
    @(negedge clk);
    check("t1_irq", 32'(interrupter), 32'h1);
    check("t1_no", 32'(interrupter_no), 32'h3);
    rd(BASE + 32'h08);
    check("t1_current", bus_rdata, 32'h103);
    wr(BASE + 32'h0C, 32'h0);
    check("t1_eoi_low", 32'(interrupter), 32'h0);
    rd(BASE + 32'h00);
    check("t1_pending", bus_rdata, 32'h0);
    irq_in = 8'h00;

    // Two simultaneous sources: priority, then one low cycle between deliveries.
    wr(BASE + 32'h04, 32'hFF);
    irq_in = 8'h22;
    repeat (4) @(negedge clk);
    check("t2_first", 32'(interrupter_no), 32'h1);
    wr(BASE + 32'h0C, 32'h0);
    check("t2_gap", 32'(interrupter), 32'h0);
    @(negedge clk);
    check("t2_second_irq", 32'(interrupter), 32'h1);
    check("t2_second_no", 32'(interrupter_no), 32'h5);
    wr(BASE + 32'h0C, 32'h0);
    irq_in = 8'h00;

    // Soft set with enable off, then enable.
    wr(BASE + 32'h04, 32'h00);
    wr(BASE + 32'h10, 32'h80);
    rd(BASE + 32'h00);
    check("t3_pending", bus_rdata, 32'h80);
    check("t3_no_deliv", 32'(interrupter), 32'h0);
    wr(BASE + 32'h04, 32'h80);
    check("t3_wait", 32'(interrupter), 32'h0);
    @(negedge clk);
    check("t3_irq", 32'(interrupter), 32'h1);
    check("t3_no", 32'(interrupter_no), 32'h7);
    wr(BASE + 32'h0C, 32'h0);

    // Clearing pending/enable while active does not end delivery; EOI in IDLE ignored.
    wr(BASE + 32'h04, 32'h04);
    wr(BASE + 32'h10, 32'h04);
    @(negedge clk);
    wr(BASE + 32'h00, 32'h04);
    wr(BASE + 32'h04, 32'h00);
    check("t4_held", 32'(interrupter), 32'h1);
    check("t4_no", 32'(interrupter_no), 32'h2);
    wr(BASE + 32'h0C, 32'h0);
    check("t4_eoi", 32'(interrupter), 32'h0);
    wr(BASE + 32'h10, 32'h10);
    wr(BASE + 32'h0C, 32'h0);
    rd(BASE + 32'h00);
    check("t4_idle_eoi", bus_rdata, 32'h10);
    wr(BASE + 32'h00, 32'hFF);

    // Edge on source 0 landing on the same edge as its EOI.
    wr(BASE + 32'h04, 32'h01);
    irq_in = 8'h01;
    repeat (4) @(negedge clk);
    check("t5_active", 32'(interrupter), 32'h1);
    irq_in = 8'h00;
    repeat (4) @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    wr(BASE + 32'h0C, 32'h0);
    check("t5_low", 32'(interrupter), 32'h0);
    @(negedge clk);
    check("t5_redeliver", 32'(interrupter), 32'h1);
    check("t5_no", 32'(interrupter_no), 32'h0);
    wr(BASE + 32'h0C, 32'h0);
    irq_in = 8'h00;

    // Reset mid-delivery, unmapped offset, and out-of-window read.
    wr(BASE + 32'h04, 32'h02);
    wr(BASE + 32'h10, 32'h02);
    @(negedge clk);
    check("t6_active", 32'(interrupter), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_irq", 32'(interrupter), 32'h0);
    check("t6_rst_no", 32'(interrupter_no), 32'h0);
    rst = 1'b0;
    rd(BASE + 32'h14);
    check("t6_hole_hit", 32'(bus_hit), 32'h1);
    check("t6_hole_data", bus_rdata, 32'h0);
    rd(BASE - 32'h4);
    check("t6_miss_hit", 32'(bus_hit), 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] off;
      if ($urandom_range(0, 5) == 0) irq_in = irq_in ^ 8'(1 << $urandom_range(0, 7));
      off       = 3'($urandom_range(0, 7));
      bus_ren   = ($urandom_range(0, 3) == 0);
      bus_wen   = ($urandom_range(0, 2) == 0);
      bus_addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : (BASE | 32'({off, 2'b00}));
      bus_wdata = 32'($urandom);
      rst       = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    rst = 1'b0; bus_ren = 1'b0; bus_wen = 1'b0; bus_addr = 32'h0; irq_in = 8'h00;
    repeat (3) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
